// File: rtl/t07_mem_pkg.sv
// rtl/t07_mem_pkg.sv - shared types for the instruction/data memory arbiter
// Contents:
//   rwi_e      external bus command encoding (idle/read/write/fetch)
//   state_e    arbiter FSM states
//   TIMEOUT_W  width of the transaction timeout counter
package t07_mem_pkg;

  typedef enum logic [1:0] {
    RWI_IDLE  = 2'b00,
    RWI_READ  = 2'b01,
    RWI_WRITE = 2'b10,
    RWI_FETCH = 2'b11
  } rwi_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int unsigned TIMEOUT_W = 8;

endpackage

// File: rtl/t07_busy_edge.sv
// rtl/t07_busy_edge.sv - falling-edge detector for the external busy line
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   busy        external memory busy (raw)
//   busy_fall   high in the cycle busy is 0 after being 1 the cycle before
module t07_busy_edge (
  input  logic clk,
  input  logic nrst,
  input  logic busy,
  output logic busy_fall
);

  logic busy_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy;
    end
  end

  assign busy_fall = busy_q & ~busy;

endmodule

// File: rtl/t07_mem_arbiter.sv
// rtl/t07_mem_arbiter.sv - round-robin fetch/data arbiter onto one external memory bus
// Ports:
//   clk, nrst                       clock, asynchronous active-low reset
//   fetch_req_i/addr_i              instruction fetch request and PC
//   fetch_inst_o/done_o             fetched word and one-cycle completion pulse
//   data_req_i/we_i/addr_i/wdata_i  load/store request
//   data_rdata_o/done_o             load data and one-cycle completion pulse
//   fpu_busy_i                      FPU multi-cycle op in progress (stalls CPU)
//   ext_busy_i/rdata_i              external memory handshake and read data
//   ext_addr_o/wdata_o/rwi_o        external address, write data, command
//   freeze_o                        CPU stall
//   timeout_err_o                   sticky timeout flag, cleared only by reset
module t07_mem_arbiter
  import t07_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] fetch_inst_o,
  output logic        fetch_done_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_done_o,
  input  logic        fpu_busy_i,
  input  logic        ext_busy_i,
  input  logic [31:0] ext_rdata_i,
  output logic [31:0] ext_addr_o,
  output logic [31:0] ext_wdata_o,
  output logic [1:0]  ext_rwi_o,
  output logic        freeze_o,
  output logic        timeout_err_o
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_e               state;
  rwi_e                 cmd_q;
  logic                 last_grant_fetch;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W-1:0] tmo_next;
  logic                 busy_fall;
  logic                 any_req;
  logic                 grant_fetch;
  logic                 normal_done;
  logic                 complete;
  logic [31:0]          rd_value;

  t07_busy_edge u_busy_edge (
    .clk       (clk),
    .nrst      (nrst),
    .busy      (ext_busy_i),
    .busy_fall (busy_fall)
  );

  always_comb begin
    any_req     = fetch_req_i | data_req_i;
    // Fetch wins when alone, or when both are pending and data won the last contest.
    grant_fetch = fetch_req_i & (~data_req_i | ~last_grant_fetch);
    tmo_next    = tmo_cnt + 1'b1;
    normal_done = (state == ST_WAIT) && busy_fall;
    // A real completion beats a timeout landing in the same cycle.
    complete    = normal_done ||
                  (((state == ST_REQ) || (state == ST_WAIT)) && (tmo_next == TIMEOUT_LIMIT));
    rd_value    = normal_done ? ext_rdata_i : 32'h0;
  end

  // The command register is the bus command, so it also tells DONE which requester to answer.
  assign ext_rwi_o = cmd_q;

  // Reset gating keeps every output low while nrst is asserted, even with requests pending.
  assign freeze_o = nrst & (fpu_busy_i | (state == ST_REQ) | (state == ST_WAIT) |
                            ((state == ST_IDLE) & any_req));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state            <= ST_IDLE;
      cmd_q            <= RWI_IDLE;
      last_grant_fetch <= 1'b1;
      tmo_cnt          <= '0;
      ext_addr_o       <= 32'h0;
      ext_wdata_o      <= 32'h0;
      fetch_inst_o     <= 32'h0;
      fetch_done_o     <= 1'b0;
      data_rdata_o     <= 32'h0;
      data_done_o      <= 1'b0;
      timeout_err_o    <= 1'b0;
    end else begin
      fetch_done_o <= 1'b0;
      data_done_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state   <= ST_REQ;
            tmo_cnt <= '0;
            // Only a contested grant moves the round-robin pointer; a lone requester
            // does not cost the other side its turn.
            if (fetch_req_i && data_req_i) begin
              last_grant_fetch <= grant_fetch;
            end
            if (grant_fetch) begin
              cmd_q      <= RWI_FETCH;
              ext_addr_o <= fetch_addr_i;
            end else begin
              cmd_q       <= data_we_i ? RWI_WRITE : RWI_READ;
              ext_addr_o  <= data_addr_i;
              ext_wdata_o <= data_wdata_i;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          tmo_cnt <= tmo_next;
          if (complete) begin
            state <= ST_DONE;
            cmd_q <= RWI_IDLE;
            if (!normal_done) begin
              timeout_err_o <= 1'b1;
            end
            case (cmd_q)
              RWI_FETCH: begin
                fetch_done_o <= 1'b1;
                fetch_inst_o <= rd_value;
              end
              RWI_READ: begin
                data_done_o  <= 1'b1;
                data_rdata_o <= rd_value;
              end
              default: data_done_o <= 1'b1;
            endcase
          end else if ((state == ST_REQ) && ext_busy_i) begin
            state <= ST_WAIT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// tb/tb_t07_mem_arbiter.sv - directed self-checking bench for t07_mem_arbiter
module tb_t07_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        fetch_req_i = 1'b0;
  logic [31:0] fetch_addr_i = 32'h0;
  logic [31:0] fetch_inst_o;
  logic        fetch_done_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [31:0] data_addr_i = 32'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic [31:0] data_rdata_o;
  logic        data_done_o;
  logic        fpu_busy_i = 1'b0;
  logic        ext_busy_i = 1'b0;
  logic [31:0] ext_rdata_i = 32'h0;
  logic [31:0] ext_addr_o;
  logic [31:0] ext_wdata_o;
  logic [1:0]  ext_rwi_o;
  logic        freeze_o;
  logic        timeout_err_o;

  logic [133:0] all_out;
  assign all_out = {fetch_inst_o, fetch_done_o, data_rdata_o, data_done_o, ext_addr_o,
                    ext_wdata_o, ext_rwi_o, freeze_o, timeout_err_o};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  t07_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .fetch_req_i   (fetch_req_i),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_inst_o  (fetch_inst_o),
    .fetch_done_o  (fetch_done_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .data_done_o   (data_done_o),
    .fpu_busy_i    (fpu_busy_i),
    .ext_busy_i    (ext_busy_i),
    .ext_rdata_i   (ext_rdata_i),
    .ext_addr_o    (ext_addr_o),
    .ext_wdata_o   (ext_wdata_o),
    .ext_rwi_o     (ext_rwi_o),
    .freeze_o      (freeze_o),
    .timeout_err_o (timeout_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(output logic [1:0] seen, output logic ok);
    ok = 1'b0;
    seen = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (ext_rwi_o != 2'b00) begin
        seen = ext_rwi_o;
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic busy_pulse(input int n, input logic [31:0] rd);
    ext_busy_i = 1'b1;
    repeat (n) tick();
    ext_busy_i = 1'b0;
    ext_rdata_i = rd;
  endtask

  task automatic wait_done(output logic f, output logic d, output logic ok);
    ok = 1'b0;
    f = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fetch_done_o || data_done_o) begin
        f = fetch_done_o;
        d = data_done_o;
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #3;
    n_cmp++; if (all_out !== 134'h0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    tick();
    nrst = 1'b1;
    tick();
    n_cmp++; if ({ext_rwi_o, freeze_o} !== 3'b000) begin n_bad++; $display("FAIL post_reset_idle: got %b expected 000", {ext_rwi_o, freeze_o}); end
  endtask

  task automatic test_fetch_only();
    logic [1:0] seen; logic ok; logic f; logic d;
    fetch_req_i = 1'b1;
    fetch_addr_i = 32'h0000_0010;
    #1;
    n_cmp++; if (freeze_o !== 1'b1) begin n_bad++; $display("FAIL fetch_freeze_idle_req: got %b expected 1", freeze_o); end
    wait_cmd(seen, ok);
    n_cmp++; if ({ok, seen} !== 3'b111) begin n_bad++; $display("FAIL fetch_cmd: got %b expected 111", {ok, seen}); end
    n_cmp++; if (ext_addr_o !== 32'h0000_0010) begin n_bad++; $display("FAIL fetch_addr: got %h expected 00000010", ext_addr_o); end
    busy_pulse(2, 32'h0000_0093);
    wait_done(f, d, ok);
    n_cmp++; if ({ok, f, d} !== 3'b110) begin n_bad++; $display("FAIL fetch_done: got %b expected 110", {ok, f, d}); end
    n_cmp++; if (fetch_inst_o !== 32'h0000_0093) begin n_bad++; $display("FAIL fetch_inst: got %h expected 00000093", fetch_inst_o); end
    n_cmp++; if (ext_rwi_o !== 2'b00) begin n_bad++; $display("FAIL fetch_done_rwi: got %b expected 00", ext_rwi_o); end
    fetch_req_i = 1'b0;
    tick();
    n_cmp++; if ({fetch_done_o, freeze_o} !== 2'b00) begin n_bad++; $display("FAIL fetch_after_done: got %b expected 00", {fetch_done_o, freeze_o}); end
    n_cmp++; if (fetch_inst_o !== 32'h0000_0093) begin n_bad++; $display("FAIL fetch_inst_hold: got %h expected 00000093", fetch_inst_o); end
  endtask

  task automatic test_arbitration();
    logic [1:0] seen; logic ok; logic f; logic d;
    // First contested pair: pointer still says fetch, so data goes first.
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0000_0100;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h3000_0000;
    wait_cmd(seen, ok);
    n_cmp++; if ({ok, seen, ext_addr_o} !== {3'b101, 32'h3000_0000}) begin n_bad++; $display("FAIL arb1_first: got %b %h expected 101 30000000", {ok, seen}, ext_addr_o); end
    busy_pulse(1, 32'h1111_2222);
    wait_done(f, d, ok);
    n_cmp++; if ({ok, f, d, data_rdata_o} !== {3'b101, 32'h1111_2222}) begin n_bad++; $display("FAIL arb1_load_done: got %b %h expected 101 11112222", {ok, f, d}, data_rdata_o); end
    data_req_i = 1'b0;
    wait_cmd(seen, ok);
    n_cmp++; if ({ok, seen, ext_addr_o} !== {3'b111, 32'h0000_0100}) begin n_bad++; $display("FAIL arb1_second: got %b %h expected 111 00000100", {ok, seen}, ext_addr_o); end
    busy_pulse(1, 32'h0000_0013);
    wait_done(f, d, ok);
    n_cmp++; if ({ok, f, d, fetch_inst_o} !== {3'b110, 32'h0000_0013}) begin n_bad++; $display("FAIL arb1_fetch_done: got %b %h expected 110 00000013", {ok, f, d}, fetch_inst_o); end
    fetch_req_i = 1'b0;
    tick();
    // Second contested pair: data won the last contest, so fetch goes first.
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0000_0104;
    data_req_i = 1'b1; data_addr_i = 32'h3000_0008;
    wait_cmd(seen, ok);
    n_cmp++; if ({ok, seen, ext_addr_o} !== {3'b111, 32'h0000_0104}) begin n_bad++; $display("FAIL arb2_first: got %b %h expected 111 00000104", {ok, seen}, ext_addr_o); end
    busy_pulse(1, 32'h0000_0017);
    wait_done(f, d, ok);
    n_cmp++; if ({ok, f, d, fetch_inst_o} !== {3'b110, 32'h0000_0017}) begin n_bad++; $display("FAIL arb2_fetch_done: got %b %h expected 110 00000017", {ok, f, d}, fetch_inst_o); end
    fetch_req_i = 1'b0;
    wait_cmd(seen, ok);
    n_cmp++; if ({ok, seen, ext_addr_o} !== {3'b101, 32'h3000_0008}) begin n_bad++; $display("FAIL arb2_second: got %b %h expected 101 30000008", {ok, seen}, ext_addr_o); end
    busy_pulse(1, 32'h3333_4444);
    wait_done(f, d, ok);
    n_cmp++; if ({ok, f, d, data_rdata_o} !== {3'b101, 32'h3333_4444}) begin n_bad++; $display("FAIL arb2_load_done: got %b %h expected 101 33334444", {ok, f, d}, data_rdata_o); end
    data_req_i = 1'b0;
    tick();
  endtask

  task automatic test_store_latency();
    data_req_i = 1'b1; data_we_i = 1'b1;
    data_addr_i = 32'h2000_0004; data_wdata_i = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if ({ext_rwi_o, ext_addr_o, ext_wdata_o} !== {2'b10, 32'h2000_0004, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL store_req: got %b %h %h expected 10 20000004 deadbeef", ext_rwi_o, ext_addr_o, ext_wdata_o); end
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    ext_busy_i = 1'b1;
    tick();
    n_cmp++; if ({ext_rwi_o, ext_addr_o, ext_wdata_o, data_done_o} !== {2'b10, 32'h2000_0004, 32'hDEAD_BEEF, 1'b0}) begin n_bad++; $display("FAIL store_wait_hold: got %b %h %h %b expected 10 20000004 deadbeef 0", ext_rwi_o, ext_addr_o, ext_wdata_o, data_done_o); end
    ext_busy_i = 1'b0; ext_rdata_i = 32'hBAD0_BAD0;
    tick();
    n_cmp++; if ({data_done_o, fetch_done_o, ext_rwi_o} !== 4'b1000) begin n_bad++; $display("FAIL store_done_at_4: got %b expected 1000", {data_done_o, fetch_done_o, ext_rwi_o}); end
    n_cmp++; if (data_rdata_o !== 32'h3333_4444) begin n_bad++; $display("FAIL store_rdata_kept: got %h expected 33334444", data_rdata_o); end
    data_req_i = 1'b0; data_we_i = 1'b0;
    tick();
    n_cmp++; if ({data_done_o, ext_addr_o, ext_wdata_o} !== {1'b0, 32'h2000_0004, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL store_idle_hold: got %b %h %h expected 0 20000004 deadbeef", data_done_o, ext_addr_o, ext_wdata_o); end
  endtask

  task automatic test_timeout();
    logic [1:0] seen; logic ok;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0040;
    wait_cmd(seen, ok);
    n_cmp++; if ({ok, seen} !== 3'b101) begin n_bad++; $display("FAIL tmo_cmd: got %b expected 101", {ok, seen}); end
    data_req_i = 1'b0;
    repeat (7) tick();
    n_cmp++; if ({data_done_o, timeout_err_o, ext_rwi_o} !== 4'b0001) begin n_bad++; $display("FAIL tmo_before_limit: got %b expected 0001", {data_done_o, timeout_err_o, ext_rwi_o}); end
    tick();
    n_cmp++; if ({data_done_o, timeout_err_o, ext_rwi_o, data_rdata_o} !== {4'b1100, 32'h0}) begin n_bad++; $display("FAIL tmo_done: got %b %h expected 1100 00000000", {data_done_o, timeout_err_o, ext_rwi_o}, data_rdata_o); end
    tick();
    n_cmp++; if ({data_done_o, timeout_err_o, ext_rwi_o, freeze_o} !== 5'b01000) begin n_bad++; $display("FAIL tmo_back_idle: got %b expected 01000", {data_done_o, timeout_err_o, ext_rwi_o, freeze_o}); end
  endtask

  task automatic test_reset_in_wait();
    logic [1:0] seen; logic ok; logic f; logic d; logic saw_done;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0050;
    wait_cmd(seen, ok);
    ext_busy_i = 1'b1;
    tick();
    #2 nrst = 1'b0;
    #1;
    n_cmp++; if (all_out !== 134'h0) begin n_bad++; $display("FAIL async_reset_outputs: got %h expected 0", all_out); end
    data_req_i = 1'b0; ext_busy_i = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_done = saw_done | fetch_done_o | data_done_o;
    end
    nrst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      saw_done = saw_done | fetch_done_o | data_done_o;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL reset_no_done: got %b expected 0", saw_done); end
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0000_0020;
    wait_cmd(seen, ok);
    n_cmp++; if ({ok, seen, ext_addr_o} !== {3'b111, 32'h0000_0020}) begin n_bad++; $display("FAIL rst_fetch_cmd: got %b %h expected 111 00000020", {ok, seen}, ext_addr_o); end
    busy_pulse(1, 32'h0000_0055);
    wait_done(f, d, ok);
    n_cmp++; if ({ok, f, d, fetch_inst_o, timeout_err_o} !== {3'b110, 32'h0000_0055, 1'b0}) begin n_bad++; $display("FAIL rst_fetch_done: got %b %h %b expected 110 00000055 0", {ok, f, d}, fetch_inst_o, timeout_err_o); end
    fetch_req_i = 1'b0;
    tick();
  endtask

  task automatic test_fpu_freeze();
    fpu_busy_i = 1'b1;
    #1;
    n_cmp++; if ({freeze_o, ext_rwi_o} !== 3'b100) begin n_bad++; $display("FAIL fpu_freeze: got %b expected 100", {freeze_o, ext_rwi_o}); end
    tick();
    n_cmp++; if ({freeze_o, ext_rwi_o} !== 3'b100) begin n_bad++; $display("FAIL fpu_freeze_hold: got %b expected 100", {freeze_o, ext_rwi_o}); end
    fpu_busy_i = 1'b0;
    #1;
    n_cmp++; if (freeze_o !== 1'b0) begin n_bad++; $display("FAIL fpu_release: got %b expected 0", freeze_o); end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_arbitration();
    test_store_latency();
    test_timeout();
    test_reset_in_wait();
    test_fpu_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
